serial_addsub_ctrl: RTL

Bit-serial add/subtract controller that sequences one shared full-adder cell, the NAND-built FA/HA datapath, over WIDTH clock cycles. It produces a WIDTH-bit sum or difference with carry/borrow and signed overflow. The block sits between a requester, which uses a start/busy/done handshake, and the single-bit adder resource, so that a wide operation costs one FA instead of WIDTH of them.

---
 rtl/serial_addsub_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one NAND-built full-adder cell is reused
// over WIDTH cycles, and a start/busy/done handshake faces the requester.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   sa, sb, acc, acc_next;
  logic [CNT_W-1:0]   cnt;
  logic               carry, sub_q;
  logic               last_bit;
  logic               fa_x, fa_y, g1, g2, ha_s, bit_s, carry_next;

  // Shared full adder built from two NAND half adders; carry is NAND of the
  // two half-adder NAND terms, i.e. majority(x, y, carry).
  assign fa_x       = sa[0];
  assign fa_y       = sb[0];
  assign g1         = ~(fa_x & fa_y);
  assign ha_s       = ~(~(fa_x & g1) & ~(fa_y & g1));
  assign g2         = ~(ha_s & carry);
  assign bit_s      = ~(~(ha_s & g2) & ~(carry & g2));
  assign carry_next = ~(g1 & g2);

  assign acc_next = {bit_s, acc[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // busy/done decode the state register only, so no input reaches them combinationally.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the default assignment first keeps this purely combinational;
  // any path that left state_next unassigned would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      acc      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sub_q    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= sub ? ~b : b;
            sub_q <= sub;
            carry <= sub;  // the +1 of a + ~b + 1
            cnt   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          acc   <= acc_next;
          carry <= carry_next;
          if (!last_bit) cnt <= cnt + CNT_W'(1);
          if (last_bit) begin
            result   <= acc_next;
            cout     <= sub_q ? ~carry_next : carry_next;
            overflow <= carry ^ carry_next;  // carry into MSB vs carry out
          end
        end
        default: ;
      endcase
    end
  end

endmodule
